// File: rtl/decode_stage.sv
// rtl/decode_stage.sv - Y86-64 decode stage: register file, source/dest select, forwarding, E register
// Optional macro DECODE_FWD_EN enables the e/M/W forwarding paths into valA/valB.
module decode_stage #(
    parameter int               WIDTH    = 64,
    parameter logic [WIDTH-1:0] RSP_INIT = '0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [3:0]       D_icode,
    input  logic [3:0]       D_ifun,
    input  logic [3:0]       D_rA,
    input  logic [3:0]       D_rB,
    input  logic [WIDTH-1:0] D_valC,
    input  logic [WIDTH-1:0] D_valP,
    input  logic [1:0]       D_stat,
    input  logic             E_stall,
    input  logic             E_bubble,
    input  logic [3:0]       e_dstE,
    input  logic [WIDTH-1:0] e_valE,
    input  logic [3:0]       M_dstE,
    input  logic [3:0]       M_dstM,
    input  logic [WIDTH-1:0] M_valE,
    input  logic [WIDTH-1:0] m_valM,
    input  logic [3:0]       W_dstE,
    input  logic [3:0]       W_dstM,
    input  logic [WIDTH-1:0] W_valE,
    input  logic [WIDTH-1:0] W_valM,
    output logic [3:0]       d_srcA,
    output logic [3:0]       d_srcB,
    output logic [3:0]       E_icode,
    output logic [3:0]       E_ifun,
    output logic [3:0]       E_dstE,
    output logic [3:0]       E_dstM,
    output logic [3:0]       E_srcA,
    output logic [3:0]       E_srcB,
    output logic [WIDTH-1:0] E_valC,
    output logic [WIDTH-1:0] E_valA,
    output logic [WIDTH-1:0] E_valB,
    output logic [1:0]       E_stat
);
    localparam logic [3:0] RNONE   = 4'hF;
    localparam logic [3:0] R_RSP   = 4'h4;
    localparam logic [3:0] I_NOP   = 4'h1;
    localparam logic [3:0] I_CMOV  = 4'h2;
    localparam logic [3:0] I_IRMOV = 4'h3;
    localparam logic [3:0] I_RMMOV = 4'h4;
    localparam logic [3:0] I_MRMOV = 4'h5;
    localparam logic [3:0] I_OP    = 4'h6;
    localparam logic [3:0] I_JXX   = 4'h7;
    localparam logic [3:0] I_CALL  = 4'h8;
    localparam logic [3:0] I_RET   = 4'h9;
    localparam logic [3:0] I_PUSH  = 4'hA;
    localparam logic [3:0] I_POP   = 4'hB;

    typedef struct packed {
        logic [3:0]       icode;
        logic [3:0]       ifun;
        logic [3:0]       dst_e;
        logic [3:0]       dst_m;
        logic [3:0]       src_a;
        logic [3:0]       src_b;
        logic [WIDTH-1:0] val_c;
        logic [WIDTH-1:0] val_a;
        logic [WIDTH-1:0] val_b;
        logic [1:0]       stat;
    } e_reg_t;

    localparam e_reg_t E_BUBBLE = '{icode: I_NOP, ifun: 4'h0, dst_e: RNONE, dst_m: RNONE,
                                    src_a: RNONE, src_b: RNONE, val_c: '0, val_a: '0,
                                    val_b: '0, stat: 2'd0};

    logic [WIDTH-1:0] regs_q [0:14];
    logic [WIDTH-1:0] regs_d [0:14];
    e_reg_t           e_q;
    e_reg_t           e_d;
    logic [3:0]       d_dstE;
    logic [3:0]       d_dstM;
    logic [WIDTH-1:0] rf_a;
    logic [WIDTH-1:0] rf_b;
    logic [WIDTH-1:0] d_valA;
    logic [WIDTH-1:0] d_valB;

    always_comb begin
        d_srcA = RNONE;
        d_srcB = RNONE;
        d_dstE = RNONE;
        d_dstM = RNONE;
        case (D_icode)
            I_CMOV:  begin d_srcA = D_rA;  d_dstE = D_rB; end
            I_IRMOV: d_dstE = D_rB;
            I_RMMOV: begin d_srcA = D_rA;  d_srcB = D_rB; end
            I_MRMOV: begin d_srcB = D_rB;  d_dstM = D_rA; end
            I_OP:    begin d_srcA = D_rA;  d_srcB = D_rB; d_dstE = D_rB; end
            I_PUSH:  begin d_srcA = D_rA;  d_srcB = R_RSP; d_dstE = R_RSP; end
            I_POP:   begin d_srcA = R_RSP; d_srcB = R_RSP; d_dstE = R_RSP; d_dstM = D_rA; end
            I_CALL:  begin d_srcB = R_RSP; d_dstE = R_RSP; end
            I_RET:   begin d_srcA = R_RSP; d_srcB = R_RSP; d_dstE = R_RSP; end
            default: ;
        endcase
    end

    // RNONE matches no entry, so it reads as zero
    always_comb begin
        rf_a = '0;
        rf_b = '0;
        for (int i = 0; i < 15; i++) begin
            if (d_srcA == 4'(i)) rf_a = regs_q[i];
            if (d_srcB == 4'(i)) rf_b = regs_q[i];
        end
    end

`ifdef DECODE_FWD_EN
    always_comb begin
        if (D_icode == I_CALL || D_icode == I_JXX) d_valA = D_valP;
        else if (d_srcA == RNONE)                  d_valA = '0;
        else if (d_srcA == e_dstE)                 d_valA = e_valE;
        else if (d_srcA == M_dstM)                 d_valA = m_valM;
        else if (d_srcA == M_dstE)                 d_valA = M_valE;
        else if (d_srcA == W_dstM)                 d_valA = W_valM;
        else if (d_srcA == W_dstE)                 d_valA = W_valE;
        else                                       d_valA = rf_a;
    end

    always_comb begin
        if (d_srcB == RNONE)       d_valB = '0;
        else if (d_srcB == e_dstE) d_valB = e_valE;
        else if (d_srcB == M_dstM) d_valB = m_valM;
        else if (d_srcB == M_dstE) d_valB = M_valE;
        else if (d_srcB == W_dstM) d_valB = W_valM;
        else if (d_srcB == W_dstE) d_valB = W_valE;
        else                       d_valB = rf_b;
    end
`else
    // Without forwarding, hazard control is expected to stall until writeback lands
    logic unused_fwd;
    assign unused_fwd = ^{e_dstE, e_valE, M_dstE, M_dstM, M_valE, m_valM};

    always_comb begin
        if (D_icode == I_CALL || D_icode == I_JXX) d_valA = D_valP;
        else                                       d_valA = rf_a;
        d_valB = rf_b;
    end
`endif

    // The M port is applied last so it wins when both ports target one register
    always_comb begin
        regs_d = regs_q;
        for (int i = 0; i < 15; i++) begin
            if (W_dstE == 4'(i)) regs_d[i] = W_valE;
            if (W_dstM == 4'(i)) regs_d[i] = W_valM;
        end
    end

    always_comb begin
        e_d = e_q;
        if (!E_stall) begin
            if (E_bubble) begin
                e_d = E_BUBBLE;
            end else begin
                e_d.icode = D_icode;
                e_d.ifun  = D_ifun;
                e_d.dst_e = d_dstE;
                e_d.dst_m = d_dstM;
                e_d.src_a = d_srcA;
                e_d.src_b = d_srcB;
                e_d.val_c = D_valC;
                e_d.val_a = d_valA;
                e_d.val_b = d_valB;
                e_d.stat  = D_stat;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 15; i++) regs_q[i] <= (i == 4) ? RSP_INIT : '0;
            e_q <= E_BUBBLE;
        end else begin
            regs_q <= regs_d;
            e_q    <= e_d;
        end
    end

    assign E_icode = e_q.icode;
    assign E_ifun  = e_q.ifun;
    assign E_dstE  = e_q.dst_e;
    assign E_dstM  = e_q.dst_m;
    assign E_srcA  = e_q.src_a;
    assign E_srcB  = e_q.src_b;
    assign E_valC  = e_q.val_c;
    assign E_valA  = e_q.val_a;
    assign E_valB  = e_q.val_b;
    assign E_stat  = e_q.stat;
endmodule

// File: tb/tb_decode_stage.sv
// tb/tb_decode_stage.sv - directed self-checking bench for decode_stage
module tb_decode_stage;
    localparam logic [63:0] RSP_RST = 64'h1000;

    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  D_icode, D_ifun, D_rA, D_rB;
    logic [63:0] D_valC, D_valP;
    logic [1:0]  D_stat;
    logic        E_stall, E_bubble;
    logic [3:0]  e_dstE;
    logic [63:0] e_valE;
    logic [3:0]  M_dstE, M_dstM;
    logic [63:0] M_valE, m_valM;
    logic [3:0]  W_dstE, W_dstM;
    logic [63:0] W_valE, W_valM;
    logic [3:0]  d_srcA, d_srcB;
    logic [3:0]  E_icode, E_ifun, E_dstE, E_dstM, E_srcA, E_srcB;
    logic [63:0] E_valC, E_valA, E_valB;
    logic [1:0]  E_stat;

    int errors = 0;
    int checks = 0;

    decode_stage #(.WIDTH(64), .RSP_INIT(RSP_RST)) dut (
        .clk(clk), .reset(reset),
        .D_icode(D_icode), .D_ifun(D_ifun), .D_rA(D_rA), .D_rB(D_rB),
        .D_valC(D_valC), .D_valP(D_valP), .D_stat(D_stat),
        .E_stall(E_stall), .E_bubble(E_bubble),
        .e_dstE(e_dstE), .e_valE(e_valE),
        .M_dstE(M_dstE), .M_dstM(M_dstM), .M_valE(M_valE), .m_valM(m_valM),
        .W_dstE(W_dstE), .W_dstM(W_dstM), .W_valE(W_valE), .W_valM(W_valM),
        .d_srcA(d_srcA), .d_srcB(d_srcB),
        .E_icode(E_icode), .E_ifun(E_ifun), .E_dstE(E_dstE), .E_dstM(E_dstM),
        .E_srcA(E_srcA), .E_srcB(E_srcB),
        .E_valC(E_valC), .E_valA(E_valA), .E_valB(E_valB), .E_stat(E_stat)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        D_icode = 4'h1; D_ifun = 4'h0; D_rA = 4'hF; D_rB = 4'hF;
        D_valC = 64'h0; D_valP = 64'h0; D_stat = 2'd0;
        E_stall = 1'b0; E_bubble = 1'b0;
        e_dstE = 4'hF; e_valE = 64'h0;
        M_dstE = 4'hF; M_dstM = 4'hF; M_valE = 64'h0; m_valM = 64'h0;
        W_dstE = 4'hF; W_dstM = 4'hF; W_valE = 64'h0; W_valM = 64'h0;
    endtask

    task automatic set_d(input logic [3:0] icode, input logic [3:0] ra, input logic [3:0] rb);
        D_icode = icode; D_ifun = 4'h0; D_rA = ra; D_rB = rb;
    endtask

    task automatic test_reset();
        idle_inputs();
        reset = 1'b1;
        step();
        step();
        reset = 1'b0;
        step();
        checks++; if (E_icode !== 4'h1) begin errors++; $display("FAIL reset_icode got=%h exp=1", E_icode); end
        checks++; if ({E_dstE, E_dstM, E_srcA, E_srcB} !== 16'hFFFF) begin errors++; $display("FAIL reset_ids got=%h exp=ffff", {E_dstE, E_dstM, E_srcA, E_srcB}); end
        checks++; if (E_valA !== 64'h0 || E_valB !== 64'h0) begin errors++; $display("FAIL reset_vals got=%h/%h exp=0/0", E_valA, E_valB); end
        checks++; if (E_stat !== 2'd0) begin errors++; $display("FAIL reset_stat got=%0d exp=0", E_stat); end
    endtask

    task automatic test_w_then_read();
        W_dstE = 4'd3; W_valE = 64'h55;
        step();
        idle_inputs();
        set_d(4'h6, 4'd3, 4'd2);
        #1;
        checks++; if (d_srcA !== 4'd3 || d_srcB !== 4'd2) begin errors++; $display("FAIL comb_src got=%h/%h exp=3/2", d_srcA, d_srcB); end
        step();
        checks++; if (E_valA !== 64'h55) begin errors++; $display("FAIL w_read_valA got=%h exp=55", E_valA); end
        checks++; if (E_dstE !== 4'd2 || E_srcA !== 4'd3 || E_srcB !== 4'd2) begin errors++; $display("FAIL w_read_ids got=%h/%h/%h exp=2/3/2", E_dstE, E_srcA, E_srcB); end
        checks++; if (E_icode !== 4'h6 || E_valB !== 64'h0) begin errors++; $display("FAIL w_read_op got=%h/%h exp=6/0", E_icode, E_valB); end
    endtask

    task automatic test_forward_priority();
        logic [63:0] exp1, exp2, exp3, exp4;
`ifdef DECODE_FWD_EN
        exp1 = 64'h10; exp2 = 64'h20; exp3 = 64'h30; exp4 = 64'h77;
`else
        exp1 = 64'h1;  exp2 = 64'h30; exp3 = 64'h30; exp4 = 64'h30;
`endif
        idle_inputs();
        W_dstE = 4'd2; W_valE = 64'h1;
        step();
        W_valE = 64'h30;
        M_dstE = 4'd2; M_valE = 64'h20;
        e_dstE = 4'd2; e_valE = 64'h10;
        set_d(4'h6, 4'd2, 4'd3);
        step();
        checks++; if (E_valA !== exp1) begin errors++; $display("FAIL fwd_e got=%h exp=%h", E_valA, exp1); end
        checks++; if (E_valB !== 64'h55) begin errors++; $display("FAIL fwd_valB_rf got=%h exp=55", E_valB); end
        e_dstE = 4'hF;
        step();
        checks++; if (E_valA !== exp2) begin errors++; $display("FAIL fwd_M got=%h exp=%h", E_valA, exp2); end
        M_dstE = 4'hF;
        step();
        checks++; if (E_valA !== exp3) begin errors++; $display("FAIL fwd_W got=%h exp=%h", E_valA, exp3); end
        W_dstE = 4'hF;
        M_dstM = 4'd2; m_valM = 64'h77;
        M_dstE = 4'd2; M_valE = 64'h20;
        step();
        checks++; if (E_valA !== exp4) begin errors++; $display("FAIL fwd_mvalM got=%h exp=%h", E_valA, exp4); end
        idle_inputs();
    endtask

    task automatic test_write_before_read();
        logic [63:0] exp;
`ifdef DECODE_FWD_EN
        exp = 64'h66;
`else
        exp = 64'h0;
`endif
        idle_inputs();
        W_dstE = 4'd6; W_valE = 64'h66;
        set_d(4'h6, 4'd6, 4'hF);
        step();
        checks++; if (E_valA !== exp) begin errors++; $display("FAIL same_cycle_wr got=%h exp=%h", E_valA, exp); end
        idle_inputs();
    endtask

    task automatic test_call_pop();
        idle_inputs();
        W_dstE = 4'd4; W_valE = 64'h100;
        step();
        idle_inputs();
        set_d(4'h8, 4'hF, 4'hF);
        D_valP = 64'h40;
        step();
        checks++; if (E_valA !== 64'h40 || E_valB !== 64'h100) begin errors++; $display("FAIL call_vals got=%h/%h exp=40/100", E_valA, E_valB); end
        checks++; if (E_dstE !== 4'd4 || E_dstM !== 4'hF) begin errors++; $display("FAIL call_dst got=%h/%h exp=4/f", E_dstE, E_dstM); end
        set_d(4'hB, 4'd5, 4'hF);
        step();
        checks++; if (E_srcA !== 4'd4 || E_dstE !== 4'd4 || E_dstM !== 4'd5) begin errors++; $display("FAIL pop_ids got=%h/%h/%h exp=4/4/5", E_srcA, E_dstE, E_dstM); end
    endtask

    task automatic test_stall_bubble();
        E_stall = 1'b1; E_bubble = 1'b1;
        set_d(4'h3, 4'hF, 4'd1);
        D_valC = 64'h123; D_stat = 2'd1;
        for (int k = 0; k < 2; k++) begin
            step();
            checks++; if (E_icode !== 4'hB || E_dstM !== 4'd5 || E_stat !== 2'd0) begin errors++; $display("FAIL stall_hold got=%h/%h/%0d exp=b/5/0", E_icode, E_dstM, E_stat); end
        end
        E_stall = 1'b0;
        step();
        checks++; if (E_icode !== 4'h1 || E_dstE !== 4'hF || E_dstM !== 4'hF || E_valA !== 64'h0 || E_stat !== 2'd0)
            begin errors++; $display("FAIL bubble got=%h/%h/%h/%h/%0d exp=1/f/f/0/0", E_icode, E_dstE, E_dstM, E_valA, E_stat); end
        E_bubble = 1'b0;
        step();
        checks++; if (E_icode !== 4'h3 || E_dstE !== 4'd1 || E_valC !== 64'h123 || E_stat !== 2'd1)
            begin errors++; $display("FAIL irmov_load got=%h/%h/%h/%0d exp=3/1/123/1", E_icode, E_dstE, E_valC, E_stat); end
        idle_inputs();
    endtask

    task automatic test_double_write();
        idle_inputs();
        W_dstE = 4'd7; W_dstM = 4'd7; W_valE = 64'hA; W_valM = 64'hB;
        step();
        idle_inputs();
        set_d(4'h2, 4'd7, 4'd8);
        step();
        checks++; if (E_valA !== 64'hB || E_dstE !== 4'd8) begin errors++; $display("FAIL dual_write got=%h/%h exp=b/8", E_valA, E_dstE); end
    endtask

    task automatic test_reset_midprogram();
        reset = 1'b1;
        W_dstE = 4'd9; W_valE = 64'h99;
        set_d(4'h6, 4'd9, 4'd7);
        step();
        checks++; if (E_icode !== 4'h1 || E_dstE !== 4'hF || E_valA !== 64'h0) begin errors++; $display("FAIL mid_reset_bubble got=%h/%h/%h exp=1/f/0", E_icode, E_dstE, E_valA); end
        reset = 1'b0;
        idle_inputs();
        set_d(4'h6, 4'd9, 4'd7);
        step();
        checks++; if (E_valA !== 64'h0 || E_valB !== 64'h0) begin errors++; $display("FAIL mid_reset_rf got=%h/%h exp=0/0", E_valA, E_valB); end
        set_d(4'hA, 4'd9, 4'hF);
        step();
        checks++; if (E_valB !== RSP_RST || E_srcB !== 4'd4) begin errors++; $display("FAIL rsp_init got=%h/%h exp=%h/4", E_valB, E_srcB, RSP_RST); end
    endtask

    initial begin
        reset = 1'b1;
        idle_inputs();
        test_reset();
        test_w_then_read();
        test_forward_priority();
        test_write_before_read();
        test_call_pop();
        test_stall_bubble();
        test_double_write();
        test_reset_midprogram();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/decode_stage.md
Name: decode_stage

Overview:
- Y86-64 pipeline decode stage. Directly downstream of fetch: consumes the D-register outputs (D_icode, D_ifun, D_rA, D_rB, D_valC, D_valP, D_stat).
- Contains the 15-entry register file, the source/destination selection logic and the valA/valB forwarding network.
- Owns the E pipeline register that feeds execute. Register-file writes come from the W stage.

Parameters:
- WIDTH, 64: data word width.
- RSP_INIT, 64'd0: reset value of %rsp (reg 4); all other registers reset to 0.

Ports:
- clk  input  1  clock, all state updates on posedge
- reset  input  1  synchronous, active-high
- D_icode, D_ifun, D_rA, D_rB  input  4 each  decode-stage instruction fields from fetch
- D_valC, D_valP  input  WIDTH each  constant and next-PC from fetch
- D_stat  input  2  status (0 AOK, 1 HLT, 2 ADR, 3 INS)
- E_stall, E_bubble  input  1 each  pipeline control for the E register
- e_dstE  input  4 / e_valE  input  WIDTH  execute-stage forward source
- M_dstE, M_dstM  input  4 each / M_valE, m_valM  input  WIDTH each  memory-stage forward sources
- W_dstE, W_dstM  input  4 each / W_valE, W_valM  input  WIDTH each  writeback data; these also drive the regfile write ports
- d_srcA, d_srcB  output  4 each  combinational source IDs, used by hazard control
- E_icode, E_ifun, E_dstE, E_dstM, E_srcA, E_srcB  output  4 each  E register
- E_valC, E_valA, E_valB  output  WIDTH each  E register
- E_stat  output  2  E register

Behaviour:
- RNONE = 4'hF. Register IDs 0-14 are valid.
- d_srcA:
  - rA for cmovXX(2), rmmovq(4), OPq(6), pushq(A)
  - 4 (%rsp) for popq(B), ret(9)
  - RNONE otherwise
- d_srcB:
  - rB for rmmovq, mrmovq(5), OPq
  - 4 for pushq, popq, call(8), ret
  - RNONE otherwise
- d_dstE:
  - rB for cmovXX, irmovq(3), OPq
  - 4 for pushq, popq, call, ret
  - RNONE otherwise
- d_dstM: rA for mrmovq and popq; RNONE otherwise.
- d_valA selection, first match wins:
  1. D_valP if icode is call or jXX(7)
  2. e_valE if d_srcA == e_dstE
  3. m_valM if == M_dstM
  4. M_valE if == M_dstE
  5. W_valM if == W_dstM
  6. W_valE if == W_dstE
  7. otherwise regfile[d_srcA]
- d_valB: same priority chain on d_srcB, without the valP rule.
- A source ID of RNONE never matches a forward source and yields 0.
- Register file:
  - Read is combinational.
  - On posedge, writes W_valE to W_dstE and W_valM to W_dstM. Writes to RNONE are ignored.
  - If W_dstE == W_dstM (both != RNONE), W_valM is written.
  - A same-cycle read of a register being written gets the new value via W forwarding.
- E register, on posedge, in priority order:
  - reset: bubble load, and the regfile is reset (rsp = RSP_INIT, others 0).
  - E_stall: hold all E outputs. Stall takes precedence over bubble when both are asserted.
  - E_bubble: load bubble.
  - otherwise: load D fields plus d_* values.
- Bubble values: icode 1 (nop), ifun 0, all IDs RNONE, valC/valA/valB 0, stat 0.
- Latency: one cycle from D inputs to E outputs. d_srcA/d_srcB are zero-latency.
- Reset asserted mid-program discards the in-flight E contents on that edge. Writeback is suppressed on a reset edge.

Optional Feature:
- Macro: DECODE_FWD_EN.
- Defined: full forwarding chain as above.
- Undefined: forward rules 2-6 are removed. d_valA is D_valP for call/jXX, else regfile[d_srcA]; d_valB is regfile[d_srcB]. Hazard control must then stall. The W write-before-read case still returns the old value, so the bench expects the stale value.

Test Plan:
- Reset for 2 cycles, then idle -> E_icode=1, E_dstE=E_dstM=E_srcA=E_srcB=F, E_valA=E_valB=0, E_stat=0.
- W_dstE=3, W_valE=0x55 for one cycle; then D=OPq(6,0) rA=3 rB=2 -> next edge: E_valA=0x55, E_dstE=2, E_srcA=3, E_srcB=2.
- Forward priority: regfile r2=1, W_dstE=2 (W_valE=0x30), M_dstE=2 (M_valE=0x20), e_dstE=2 (e_valE=0x10), D=OPq rA=2 -> E_valA=0x10. Drop e_dstE -> 0x20. Drop M -> 0x30.
- D=call, D_valP=0x40, rsp=0x100 -> E_valA=0x40, E_valB=0x100, E_dstE=4, E_dstM=F. Then D=popq rA=5 -> E_srcA=4, E_dstE=4, E_dstM=5.
- E_stall=1 and E_bubble=1 for 2 cycles while D changes -> E outputs unchanged. E_bubble only -> nop bubble values next edge.
- W_dstE=W_dstM=7, W_valE=0xA, W_valM=0xB -> regfile r7=0xB, observed via a later rrmovq (cmovXX) rA=7: E_valA=0xB.
